pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage pipelined cpu.
//  Holds a DEPTH-entry scoreboard of in-flight destinations (EXE..WB), detects load-use and
//  WB-read hazards, emits stall/bubble/flush, and registers ALU-operand forwarding selects for EXE.
//  Sits beside the ID stage; consumes decoded ID fields plus the taken-redirect from the branch stage.
// PARAMETERS
//  RA_W      5   register address width
//  DEPTH     3   scoreboard entries after ID (s1=EXE ... sDEPTH=WB); legal 2..7
//  BR_STAGE  2   scoreboard stage resolving branch/jump (s2=MEM); 1..DEPTH-1
//  PERF_W    16  width of stall performance counter
// PORTS
//  clk           in   1        clock, rising edge
//  arst          in   1        asynchronous reset, active-high
//  enable        in   1        global pipeline enable; low = freeze all state
//  id_valid      in   1        ID holds a real instruction
//  id_rs, id_rt  in   RA_W     ID source register addresses
//  id_use_rs/rt  in   1        ID instruction reads rs / rt
//  id_waddr      in   RA_W     ID destination register
//  id_reg_write  in   1        ID instruction writes regfile
//  id_mem_read   in   1        ID instruction is a load
//  redirect      in   1        branch taken or jump in stage s[BR_STAGE]
//  stall         out  1        hold PC and IF/ID register
//  bubble        out  1        zero control word entering ID/EXE
//  flush_id      out  1        kill IF/ID contents (load NOP)
//  fwd_a_sel     out  clog2(DEPTH) EXE operand A: 0=ID/EXE reg, k=result of s[k+1]
//  fwd_b_sel     out  clog2(DEPTH) EXE operand B, same encoding
//  stall_cnt     out  PERF_W   saturating count of stall cycles
// BEHAVIOUR
//  - Entry s[k] = {valid, reg_write, mem_read, waddr}. A producer is live if valid & reg_write & waddr!=0.
//  - Reset: all entries invalid, fwd_*_sel=0, stall_cnt=0; stall/bubble/flush_id=0 (derive from state).
//  - Match(r,k): id_valid & use_r & s[k] live & s[k].waddr==r.
//  - load-use: Match on s[1] with s[1].mem_read -> stall=1, bubble=1 (one cycle per occurrence).
//  - Matches on s[2..DEPTH-1] need no stall: forwarding covers them.
//  - stall, bubble, flush_id combinational from registers + ID inputs; zero when enable=0.
//  - Advance (enable=1, posedge): s[k]<=s[k-1] for k>=2; s[1]<=ID fields, invalidated if bubble or redirect.
//  - redirect: flush_id=1, bubble=1, stall forced 0 (redirect wins); entries s[1..BR_STAGE-1]
//    invalidated as they shift; redirect ignored when enable=0.
//  - fwd selects registered on advance: for each operand, youngest matching s[k], k in 1..DEPTH-1,
//    gives sel=k (since it sits in s[k+1] when consumer reaches EXE); no match -> 0.
//    A stalled/bubbled/redirected advance loads sel=0.
//  - Latency: hazard decision 0 cycles (same cycle as ID); fwd sel valid 1 cycle later in EXE.
//  - stall_cnt increments on every enabled cycle with stall=1; holds at all-ones.
//  - enable=0: every register holds; arst mid-operation clears all state immediately.
// CONFIGURATION
//  HAZARD_WB_BYPASS_EN defined: register file is write-through; Match on s[DEPTH] ignored.
//  Not defined: Match on s[DEPTH] (WB writing the reg ID reads this cycle) also raises
//    stall=1, bubble=1 for one cycle; stall_cnt counts it.
// TESTING
//  1 add r3,r1,r2 then sub r4,r3,r5 -> no stall; fwd_a_sel=1 in EXE of sub.
//  2 lw r3,0(r0) then add r4,r3,r3 -> stall=1,bubble=1 one cycle; then fwd_a_sel=fwd_b_sel=2.
//  3 add r3 at s[DEPTH] with ID reading r3 -> macro on: stall=0; off: stall=1 one cycle.
//  4 redirect=1 in same cycle as load-use -> stall=0, flush_id=1, s1 invalid next cycle.
//  5 writes to r0 in flight, ID reads r0 -> no stall, sel=0; enable=0 for 3 cycles -> state frozen.
//  6 arst pulse mid-stall -> outputs 0, stall_cnt=0; 2^PERF_W+5 stalls -> stall_cnt all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage <-> hazard controller bundle: decoded ID fields and branch redirect in,
// stall/bubble/flush and EXE forwarding selects out.
interface pipe_hazard_ctrl_if #(
    parameter int RA_W   = 5,
    parameter int DEPTH  = 3,
    parameter int PERF_W = 16
);
    localparam int SEL_W = $clog2(DEPTH);

    logic              enable;
    logic              id_valid;
    logic [RA_W-1:0]   id_rs;
    logic [RA_W-1:0]   id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [RA_W-1:0]   id_waddr;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              redirect;

    logic              stall;
    logic              bubble;
    logic              flush_id;
    logic [SEL_W-1:0]  fwd_a_sel;
    logic [SEL_W-1:0]  fwd_b_sel;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output enable, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_waddr, id_reg_write, id_mem_read, redirect,
        input  stall, bubble, flush_id, fwd_a_sel, fwd_b_sel, stall_cnt
    );

    modport slave (
        input  enable, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_waddr, id_reg_write, id_mem_read, redirect,
        output stall, bubble, flush_id, fwd_a_sel, fwd_b_sel, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: scoreboard of in-flight destinations.
// Optional macro HAZARD_WB_BYPASS_EN: write-through register file, so a WB-stage match never stalls.
module pipe_hazard_ctrl #(
    parameter int RA_W     = 5,
    parameter int DEPTH    = 3,
    parameter int BR_STAGE = 2,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              arst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int SEL_W = $clog2(DEPTH);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [RA_W-1:0] waddr;
    } entry_t;

    // Only the EXE entry's load flag matters, so it is kept beside the scoreboard.
    entry_t            sb [1:DEPTH];
    logic              s1_mem_read;
    logic [SEL_W-1:0]  fwd_a_q;
    logic [SEL_W-1:0]  fwd_b_q;
    logic [PERF_W-1:0] stall_cnt_q;

    logic [DEPTH:1]    match_rs;
    logic [DEPTH:1]    match_rt;
    logic              load_use;
    logic              wb_hazard;
    logic              hazard;
    logic              stall;
    logic              bubble;
    logic              flush_id;

    function automatic logic is_live(entry_t e);
        return e.valid && e.reg_write && (e.waddr != '0);
    endfunction

    // Lowest stage number wins: the youngest producer holds the newest value.
    function automatic logic [SEL_W-1:0] youngest(logic [DEPTH:1] m);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (m[k]) sel = SEL_W'(k);
        end
        return sel;
    endfunction

    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        match_rs = '0;
        match_rt = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            match_rs[k] = hz.id_valid && hz.id_use_rs && is_live(sb[k]) && (sb[k].waddr == hz.id_rs);
            match_rt[k] = hz.id_valid && hz.id_use_rt && is_live(sb[k]) && (sb[k].waddr == hz.id_rt);
        end
    end

    assign load_use = s1_mem_read && (match_rs[1] || match_rt[1]);

`ifdef HAZARD_WB_BYPASS_EN
    assign wb_hazard = 1'b0;
`else
    assign wb_hazard = match_rs[DEPTH] || match_rt[DEPTH];
`endif

    // A taken redirect kills the ID instruction anyway, so it overrides any stall.
    assign hazard   = load_use || wb_hazard;
    assign stall    = hz.enable && hazard && !hz.redirect;
    assign bubble   = hz.enable && (hazard || hz.redirect);
    assign flush_id = hz.enable && hz.redirect;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            // NOTE: the scoreboard is a handful of flops, so every entry is cleared, not just valid.
            for (int k = 1; k <= DEPTH; k++) sb[k] <= '0;
            s1_mem_read <= 1'b0;
            fwd_a_q     <= '0;
            fwd_b_q     <= '0;
            stall_cnt_q <= '0;
        end else if (hz.enable) begin
            // NOTE: non-blocking so every stage shifts from the pre-edge value of its neighbour.
            sb[1] <= '{valid:     hz.id_valid && !bubble,
                       reg_write: hz.id_reg_write,
                       waddr:     hz.id_waddr};
            s1_mem_read <= hz.id_mem_read;
            for (int k = 2; k <= DEPTH; k++) begin
                sb[k] <= '{valid:     sb[k-1].valid && !(hz.redirect && (k <= BR_STAGE)),
                           reg_write: sb[k-1].reg_write,
                           waddr:     sb[k-1].waddr};
            end
            fwd_a_q <= bubble ? '0 : youngest(match_rs);
            fwd_b_q <= bubble ? '0 : youngest(match_rt);
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
        end
    end

    assign hz.stall     = stall;
    assign hz.bubble    = bubble;
    assign hz.flush_id  = flush_id;
    assign hz.fwd_a_sel = fwd_a_q;
    assign hz.fwd_b_sel = fwd_b_q;
    assign hz.stall_cnt = stall_cnt_q;

    a_stall_bubbles: assert property (@(posedge clk) disable iff (arst) stall |-> bubble);
    a_redirect_wins: assert property (@(posedge clk) disable iff (arst) flush_id |-> !stall);
    a_sel_range_a:   assert property (@(posedge clk) disable iff (arst) int'(fwd_a_q) < DEPTH);
    a_sel_range_b:   assert property (@(posedge clk) disable iff (arst) int'(fwd_b_q) < DEPTH);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed pipeline scenarios plus randomized traffic against a queue model.
module tb_pipe_hazard_ctrl;
    localparam int RA_W     = 5;
    localparam int DEPTH    = 3;
    localparam int BR_STAGE = 2;
    localparam int PERF_W   = 5;
    localparam int CNT_MAX  = (1 << PERF_W) - 1;
`ifdef HAZARD_WB_BYPASS_EN
    localparam bit WB_STALL = 1'b0;
`else
    localparam bit WB_STALL = 1'b1;
`endif

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RA_W(RA_W), .DEPTH(DEPTH), .PERF_W(PERF_W)) hz ();

    pipe_hazard_ctrl #(.RA_W(RA_W), .DEPTH(DEPTH), .BR_STAGE(BR_STAGE), .PERF_W(PERF_W)) dut (
        .clk  (clk),
        .arst (arst),
        .hz   (hz)
    );

    typedef struct {
        bit valid;
        bit rw;
        bit mr;
        int waddr;
    } rec_t;

    rec_t pipe[$];  // pipe[0] is EXE (s1), pipe[DEPTH-1] is WB
    int   m_fwd_a, m_fwd_b, m_cnt;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(rec_t'{valid: 0, rw: 0, mr: 0, waddr: 0});
        m_fwd_a = 0;
        m_fwd_b = 0;
        m_cnt   = 0;
    endtask

    function automatic bit m_match(input int k, input bit use_r, input int r);
        rec_t e;
        e = pipe[k-1];
        return hz.id_valid && use_r && e.valid && e.rw && (e.waddr != 0) && (e.waddr == r);
    endfunction

    function automatic bit m_hazard();
        bit lu, wb;
        lu = (m_match(1, hz.id_use_rs, int'(hz.id_rs)) || m_match(1, hz.id_use_rt, int'(hz.id_rt)))
             && pipe[0].mr;
        wb = WB_STALL && (m_match(DEPTH, hz.id_use_rs, int'(hz.id_rs)) ||
                          m_match(DEPTH, hz.id_use_rt, int'(hz.id_rt)));
        return lu || wb;
    endfunction

    function automatic bit m_stall();
        return hz.enable && m_hazard() && !hz.redirect;
    endfunction

    function automatic bit m_bubble();
        return hz.enable && (m_hazard() || hz.redirect);
    endfunction

    function automatic int m_youngest(input bit use_r, input int r);
        for (int k = 1; k < DEPTH; k++) if (m_match(k, use_r, r)) return k;
        return 0;
    endfunction

    task automatic model_advance();
        bit bub, st;
        int na, nb;
        if (!hz.enable) return;
        bub = m_bubble();
        st  = m_stall();
        na  = bub ? 0 : m_youngest(hz.id_use_rs, int'(hz.id_rs));
        nb  = bub ? 0 : m_youngest(hz.id_use_rt, int'(hz.id_rt));
        if (st && m_cnt < CNT_MAX) m_cnt++;
        if (hz.redirect) for (int i = 0; i < BR_STAGE - 1; i++) pipe[i].valid = 0;
        pipe.push_front(rec_t'{valid: hz.id_valid && !bub, rw: hz.id_reg_write,
                               mr: hz.id_mem_read, waddr: int'(hz.id_waddr)});
        void'(pipe.pop_back());
        m_fwd_a = na;
        m_fwd_b = nb;
    endtask

    task automatic compare_cycle();
        #1;
        check("stall",     hz.stall,     m_stall());
        check("bubble",    hz.bubble,    m_bubble());
        check("flush_id",  hz.flush_id,  hz.enable && hz.redirect);
        check("fwd_a_sel", hz.fwd_a_sel, m_fwd_a);
        check("fwd_b_sel", hz.fwd_b_sel, m_fwd_b);
        check("stall_cnt", hz.stall_cnt, m_cnt);
    endtask

    task automatic tick();
        compare_cycle();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic drive_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                            input int wa, input bit rw, input bit mr);
        hz.id_valid     = v;
        hz.id_rs        = RA_W'(rs);
        hz.id_rt        = RA_W'(rt);
        hz.id_use_rs    = urs;
        hz.id_use_rt    = urt;
        hz.id_waddr     = RA_W'(wa);
        hz.id_reg_write = rw;
        hz.id_mem_read  = mr;
    endtask

    task automatic flush_pipe();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        hz.redirect = 0;
        hz.enable   = 1;
        repeat (DEPTH) tick();
    endtask

    task automatic reset_pulse();
        hz.redirect = 0;
        arst        = 1;
        model_reset();
        compare_cycle();
        @(posedge clk);
        @(negedge clk);
        arst = 0;
    endtask

    initial begin
        arst        = 1;
        hz.enable   = 1;
        hz.redirect = 0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", hz.stall, 0);
        check("rst_bubble", hz.bubble, 0);
        check("rst_flush", hz.flush_id, 0);
        check("rst_fwd_a", hz.fwd_a_sel, 0);
        check("rst_cnt", hz.stall_cnt, 0);
        arst = 0;
        @(negedge clk);

        // add r3,r1,r2 ; sub r4,r3,r5
        drive_id(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        drive_id(1, 3, 5, 1, 1, 4, 1, 0);
        #1 check("t1_stall", hz.stall, 0);
        tick();
        check("t1_fwd_a", hz.fwd_a_sel, 1);
        check("t1_fwd_b", hz.fwd_b_sel, 0);
        flush_pipe();

        // lw r3,0(r0) ; add r4,r3,r3
        drive_id(1, 0, 0, 1, 0, 3, 1, 1);
        tick();
        drive_id(1, 3, 3, 1, 1, 4, 1, 0);
        #1;
        check("t2_stall", hz.stall, 1);
        check("t2_bubble", hz.bubble, 1);
        check("t2_flush", hz.flush_id, 0);
        tick();
        #1 check("t2_stall_gone", hz.stall, 0);
        tick();
        check("t2_fwd_a", hz.fwd_a_sel, 2);
        check("t2_fwd_b", hz.fwd_b_sel, 2);
        check("t2_cnt", hz.stall_cnt, 1);
        flush_pipe();

        // add r3 reaches WB while ID reads r3
        drive_id(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        drive_id(1, 3, 0, 1, 0, 5, 1, 0);
        #1 check("t3_wb_stall", hz.stall, WB_STALL);
        tick();
        #1 check("t3_wb_after", hz.stall, 0);
        tick();
        flush_pipe();

        // redirect in the same cycle as a load-use
        drive_id(1, 0, 0, 1, 0, 3, 1, 1);
        tick();
        drive_id(1, 3, 0, 1, 0, 4, 1, 1);
        hz.redirect = 1;
        #1;
        check("t4_stall", hz.stall, 0);
        check("t4_flush", hz.flush_id, 1);
        check("t4_bubble", hz.bubble, 1);
        tick();
        hz.redirect = 0;
        drive_id(1, 4, 3, 1, 1, 6, 1, 0);
        #1 check("t4_s1_killed", hz.stall, 0);
        tick();
        check("t4_fwd_a", hz.fwd_a_sel, 0);
        check("t4_fwd_b", hz.fwd_b_sel, 0);
        flush_pipe();

        // r0 writers in flight, then a frozen pipeline
        drive_id(1, 0, 0, 0, 0, 0, 1, 1);
        repeat (2) tick();
        drive_id(1, 0, 0, 1, 1, 5, 1, 0);
        #1 check("t5_r0_stall", hz.stall, 0);
        tick();
        check("t5_r0_fwd_a", hz.fwd_a_sel, 0);
        check("t5_r0_fwd_b", hz.fwd_b_sel, 0);
        drive_id(1, 0, 0, 0, 0, 6, 1, 1);
        tick();
        hz.enable   = 0;
        hz.redirect = 1;
        drive_id(1, 6, 6, 1, 1, 7, 1, 0);
        repeat (3) begin
            #1;
            check("t5_frz_stall", hz.stall, 0);
            check("t5_frz_flush", hz.flush_id, 0);
            tick();
        end
        hz.enable   = 1;
        hz.redirect = 0;
        #1 check("t5_thaw_stall", hz.stall, 1);
        tick();
        tick();
        check("t5_thaw_fwd_a", hz.fwd_a_sel, 2);
        flush_pipe();

        // asynchronous reset in the middle of a stall
        drive_id(1, 0, 0, 0, 0, 2, 1, 1);
        tick();
        drive_id(1, 2, 0, 1, 0, 8, 1, 0);
        #1 check("t6_pre_stall", hz.stall, 1);
        arst = 1;
        #1;
        check("t6_rst_stall", hz.stall, 0);
        check("t6_rst_bubble", hz.bubble, 0);
        check("t6_rst_cnt", hz.stall_cnt, 0);
        check("t6_rst_fwd_b", hz.fwd_b_sel, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        arst = 0;

        // back-to-back self-dependent loads stall every other cycle until the counter saturates
        drive_id(1, 7, 0, 1, 0, 7, 1, 1);
        for (int i = 0; i < 2 * ((1 << PERF_W) + 5); i++) tick();
        check("t6_cnt_sat", hz.stall_cnt, CNT_MAX);
        reset_pulse();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_pulse();
                continue;
            end
            hz.enable   = ($urandom_range(0, 9) != 0);
            hz.redirect = ($urandom_range(0, 9) == 0);
            drive_id($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 3),
                     $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
